// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants and state type for the round-robin mux arbiter
//
// Purpose: sizes of the requester vector, select bus and hold counter, plus
// the two-state arbiter FSM encoding. Imported by rr_pick16 and mux_rr_arbiter.
// Ports: none (package).
package mux_arb_pkg;

  localparam int NREQ   = 16;
  localparam int SEL_W  = 4;
  localparam int HOLD_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick16.sv
// rtl/rr_pick16.sv - combinational round-robin pick among 16 requesters
//
// Purpose: finds the first set request bit searching last+1, last+2, ...
// wrapping 15->0, so the previous winner ends up with lowest priority.
// Ports:
//   req   [15:0] in  live request vector
//   last  [3:0]  in  index of the previous owner
//   idx   [3:0]  out winning index (meaningful only when found=1)
//   found        out at least one request bit is set
module rr_pick16
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0]  offset;
  logic [SEL_W-1:0]  pos;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;

  // Rotating right by last+1 puts the highest-priority requester at bit 0,
  // so a plain lowest-bit-first priority encoder does the round-robin search.
  assign offset = last + SEL_W'(1);
  assign dbl    = {req, req};
  assign rot    = dbl[offset +: NREQ];

  always_comb begin
    pos   = '0;
    found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pos   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

  // 4-bit addition wraps mod 16, undoing the rotation.
  assign idx = pos + offset;

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin owner arbiter driving a 16:1 mux select
//
// Purpose: grants the shared 16:1 selector to one requester at a time, holds
// the select until done, request withdrawal or optional MAX_HOLD expiry,
// then rotates priority so the last owner becomes lowest priority.
// Ports:
//   clk             in  rising-edge clock
//   resetn          in  asynchronous active-low reset
//   req      [15:0] in  request vector, bit i = requester i
//   done            in  release pulse from the current owner
//   sel      [3:0]  out mux select, index of current/last owner
//   gnt      [15:0] out one-hot grant (zero when no grant)
//   gnt_valid       out a grant is active
//   timeout         out one-cycle pulse after a grant is revoked by MAX_HOLD
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [NREQ-1:0]  gnt,
  output logic             gnt_valid,
  output logic             timeout
);

  state_e            state, state_nx;
  logic [SEL_W-1:0]  last, last_nx;
  logic [SEL_W-1:0]  sel_nx;
  logic [NREQ-1:0]   gnt_nx;
  logic [HOLD_W-1:0] hold_cnt, hold_nx;
  logic              gv_nx;
  logic              to_nx;
  logic              hold_expired;
  logic              release_now;
  logic [SEL_W-1:0]  pick_idx;
  logic              pick_found;

  rr_pick16 u_pick (
    .req   (req),
    .last  (last),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign release_now  = done || !req[sel] || hold_expired;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      last      <= SEL_W'(NREQ - 1);
      sel       <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nx;
      last      <= last_nx;
      sel       <= sel_nx;
      gnt       <= gnt_nx;
      gnt_valid <= gv_nx;
      timeout   <= to_nx;
      hold_cnt  <= hold_nx;
    end
  end

  always_comb begin
    state_nx = state;
    last_nx  = last;
    sel_nx   = sel;
    gnt_nx   = gnt;
    gv_nx    = gnt_valid;
    hold_nx  = hold_cnt;
    to_nx    = 1'b0;
    case (state)
      IDLE: begin
        // sel keeps the previous owner while idle; only the grant drops.
        gv_nx  = 1'b0;
        gnt_nx = '0;
        if (pick_found) begin
          sel_nx   = pick_idx;
          gnt_nx   = NREQ'(1) << pick_idx;
          gv_nx    = 1'b1;
          hold_nx  = '0;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          last_nx  = sel;
          gv_nx    = 1'b0;
          gnt_nx   = '0;
          state_nx = IDLE;
          // Only an expiry that is not pre-empted by done or withdrawal
          // counts as a revocation.
          to_nx    = !done && req[sel];
        end else if (hold_cnt != {HOLD_W{1'b1}}) begin
          hold_nx = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

  logic        clk;
  logic        resetn;
  logic [15:0] req;
  logic        done;

  logic [3:0]  sel_a, sel_b;
  logic [15:0] gnt_a, gnt_b;
  logic        gv_a, gv_b;
  logic        to_a, to_b;

  int checks;
  int failures;

  mux_rr_arbiter #(.MAX_HOLD(0)) dut_a (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
    .done      (done),
    .sel       (sel_a),
    .gnt       (gnt_a),
    .gnt_valid (gv_a),
    .timeout   (to_a)
  );

  mux_rr_arbiter #(.MAX_HOLD(4)) dut_b (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
    .done      (done),
    .sel       (sel_b),
    .gnt       (gnt_b),
    .gnt_valid (gv_b),
    .timeout   (to_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: index 0 mirrors MAX_HOLD=0, index 1 mirrors MAX_HOLD=4.
  int mh     [2] = '{0, 4};
  bit m_busy [2];
  int m_owner[2];
  int m_last [2];
  int m_age  [2];
  bit m_to   [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_busy[m]  = 1'b0;
      m_owner[m] = 0;
      m_last[m]  = 15;
      m_age[m]   = 0;
      m_to[m]    = 1'b0;
    end
  endtask

  task automatic model_step(input logic [15:0] r, input logic d);
    for (int m = 0; m < 2; m++) begin
      m_to[m] = 1'b0;
      if (m_busy[m]) begin
        if (d || !r[m_owner[m]] || (mh[m] != 0 && m_age[m] == mh[m] - 1)) begin
          m_to[m]   = !d && r[m_owner[m]];
          m_last[m] = m_owner[m];
          m_busy[m] = 1'b0;
        end else if (m_age[m] < 255) begin
          m_age[m]++;
        end
      end else begin
        for (int k = 1; k <= 16; k++) begin
          if (r[(m_last[m] + k) % 16]) begin
            m_owner[m] = (m_last[m] + k) % 16;
            m_busy[m]  = 1'b1;
            m_age[m]   = 0;
            break;
          end
        end
      end
    end
  endtask

  task automatic check(input string nm,
                       input logic [3:0] a_sel, input logic [15:0] a_gnt,
                       input logic a_gv, input logic a_to,
                       input logic [3:0] e_sel, input logic e_gv, input logic e_to);
    logic [15:0] e_gnt;
    e_gnt = e_gv ? (16'd1 << e_sel) : 16'd0;
    checks++;
    if (a_sel !== e_sel || a_gnt !== e_gnt || a_gv !== e_gv || a_to !== e_to) begin
      failures++;
      $display("FAIL %s: got sel=%0d gnt=%h gnt_valid=%b timeout=%b, want sel=%0d gnt=%h gnt_valid=%b timeout=%b",
               nm, a_sel, a_gnt, a_gv, a_to, e_sel, e_gnt, e_gv, e_to);
    end
  endtask

  // Apply inputs away from the edge, clock once, sample 1ns after the edge.
  task automatic tick(input logic [15:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
  endtask

  typedef struct {
    logic [15:0] req;
    logic        done;
    logic [3:0]  sel;
    logic        gv;
    logic        to;
  } vec_t;

  vec_t tbl[17];

  initial begin
    logic [15:0] cur_req;
    logic        cur_done;

    checks   = 0;
    failures = 0;

    // Wrap/skip, withdrawal, idle-done and other-bit changes; one edge per row.
    tbl[0]  = '{16'h0000, 1'b1, 4'd0,  1'b0, 1'b0};  // release owner 0, last=0
    tbl[1]  = '{16'h2000, 1'b0, 4'd13, 1'b1, 1'b0};
    tbl[2]  = '{16'h2000, 1'b1, 4'd13, 1'b0, 1'b0};  // last=13
    tbl[3]  = '{16'h0009, 1'b0, 4'd0,  1'b1, 1'b0};  // wrap 15->0
    tbl[4]  = '{16'h0009, 1'b1, 4'd0,  1'b0, 1'b0};
    tbl[5]  = '{16'h0009, 1'b0, 4'd3,  1'b1, 1'b0};
    tbl[6]  = '{16'h0009, 1'b1, 4'd3,  1'b0, 1'b0};
    tbl[7]  = '{16'h0020, 1'b0, 4'd5,  1'b1, 1'b0};
    tbl[8]  = '{16'h0020, 1'b0, 4'd5,  1'b1, 1'b0};
    tbl[9]  = '{16'h0010, 1'b0, 4'd5,  1'b0, 1'b0};  // req[5] withdrawn
    tbl[10] = '{16'h0030, 1'b0, 4'd4,  1'b1, 1'b0};  // 4 wins after last=5
    tbl[11] = '{16'h0030, 1'b1, 4'd4,  1'b0, 1'b0};
    tbl[12] = '{16'h0000, 1'b0, 4'd4,  1'b0, 1'b0};  // idle keeps sel
    tbl[13] = '{16'h0000, 1'b1, 4'd4,  1'b0, 1'b0};  // done in idle ignored
    tbl[14] = '{16'h0030, 1'b0, 4'd5,  1'b1, 1'b0};
    tbl[15] = '{16'hFFE0, 1'b0, 4'd5,  1'b1, 1'b0};  // other bits change
    tbl[16] = '{16'hFFE0, 1'b1, 4'd5,  1'b0, 1'b0};  // last=5

    // Reset with everyone requesting.
    resetn = 1'b0;
    req    = 16'hFFFF;
    done   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", sel_a, gnt_a, gv_a, to_a, 4'd0, 1'b0, 1'b0);
    check("reset_b", sel_b, gnt_b, gv_b, to_b, 4'd0, 1'b0, 1'b0);
    resetn = 1'b1;
    model_reset();
    tick(16'h0001, 1'b0);
    check("first_grant", sel_a, gnt_a, gv_a, to_a, 4'd0, 1'b1, 1'b0);

    // Rotation 0..15,0 with one bubble between grants.
    for (int k = 1; k <= 16; k++) begin
      tick(16'hFFFF, 1'b1);
      check("rot_bubble", sel_a, gnt_a, gv_a, to_a, 4'((k - 1) % 16), 1'b0, 1'b0);
      tick(16'hFFFF, 1'b0);
      check("rot_grant", sel_a, gnt_a, gv_a, to_a, 4'(k % 16), 1'b1, 1'b0);
    end

    for (int i = 0; i < 17; i++) begin
      tick(tbl[i].req, tbl[i].done);
      check($sformatf("table_row%0d", i), sel_a, gnt_a, gv_a, to_a,
            tbl[i].sel, tbl[i].gv, tbl[i].to);
    end

    // Hold timeout on the MAX_HOLD=4 instance; MAX_HOLD=0 never times out.
    tick(16'h0100, 1'b0);
    check("to_grant_b", sel_b, gnt_b, gv_b, to_b, 4'd8, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(16'h0100, 1'b0);
      check("to_hold_b", sel_b, gnt_b, gv_b, to_b, 4'd8, 1'b1, 1'b0);
    end
    tick(16'h0100, 1'b0);
    check("to_revoke_b", sel_b, gnt_b, gv_b, to_b, 4'd8, 1'b0, 1'b1);
    check("to_none_a", sel_a, gnt_a, gv_a, to_a, 4'd8, 1'b1, 1'b0);
    tick(16'h0100, 1'b0);
    check("to_regrant_b", sel_b, gnt_b, gv_b, to_b, 4'd8, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(16'h0100, 1'b0);
      check("to_hold2_b", sel_b, gnt_b, gv_b, to_b, 4'd8, 1'b1, 1'b0);
    end
    tick(16'h0100, 1'b1);
    check("to_done_wins_b", sel_b, gnt_b, gv_b, to_b, 4'd8, 1'b0, 1'b0);
    check("to_done_a", sel_a, gnt_a, gv_a, to_a, 4'd8, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a grant.
    tick(16'h0200, 1'b0);
    check("ar_grant", sel_a, gnt_a, gv_a, to_a, 4'd9, 1'b1, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check("ar_immediate_a", sel_a, gnt_a, gv_a, to_a, 4'd0, 1'b0, 1'b0);
    check("ar_immediate_b", sel_b, gnt_b, gv_b, to_b, 4'd0, 1'b0, 1'b0);
    model_reset();
    resetn = 1'b1;
    tick(16'h0200, 1'b0);
    check("ar_regrant", sel_a, gnt_a, gv_a, to_a, 4'd9, 1'b1, 1'b0);
    tick(16'h0000, 1'b1);

    // Randomized traffic against the reference model, both instances.
    resetn = 1'b0;
    #2;
    model_reset();
    resetn = 1'b1;
    cur_req = 16'h0000;
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 7))
        0: cur_req = 16'($urandom) & 16'($urandom);
        1: cur_req = cur_req ^ (16'd1 << $urandom_range(0, 15));
        default: ;
      endcase
      cur_done = ($urandom_range(0, 5) == 0);
      tick(cur_req, cur_done);
      check("rnd_a", sel_a, gnt_a, gv_a, to_a, 4'(m_owner[0]), m_busy[0], m_to[0]);
      check("rnd_b", sel_b, gnt_b, gv_b, to_b, 4'(m_owner[1]), m_busy[1], m_to[1]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
